// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle restoring divider.
package div_pkg;

    localparam int DIV_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_trial_sub.sv
// One restoring-division trial step: subtract the divisor from the shifted partial remainder.
module div_trial_sub #(
    parameter int N = 16
) (
    input  logic [N:0]   shifted,
    input  logic [N-1:0] divisor,
    output logic [N:0]   diff,
    output logic         ge
);

    logic [N:0] w_div_ext;

    assign w_div_ext = {1'b0, divisor};
    assign diff      = shifted - w_div_ext;
    assign ge        = (shifted >= w_div_ext);

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle restoring unsigned divider with valid/ready handshakes on both sides.
// One quotient bit per CALC cycle; divide-by-zero short-circuits straight to DONE.
module div_sequencer
    import div_pkg::*;
#(
    parameter int N  = DIV_W,
    parameter int CW = $clog2(N + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    input  logic         abort,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero,
    output logic         busy
);

    localparam logic [CW-1:0] CNT_INIT = CW'(N);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    div_state_e    r_state;
    div_state_e    w_state_next;
    logic [CW-1:0] r_count;
    logic [N:0]    r_rem;
    logic [N-1:0]  r_q;
    logic [N-1:0]  r_div;
    logic [N-1:0]  r_quotient;
    logic [N-1:0]  r_remainder;
    logic          r_dbz;
    logic          r_out_valid;
    logic          r_in_ready;
    logic          r_busy;

    logic          w_out_valid_next;
    logic          w_dbz_next;
    logic          w_accept;
    logic          w_div_zero;
    logic          w_last;
    logic [N:0]    w_shifted;
    logic [N:0]    w_diff;
    logic          w_ge;
    logic [N:0]    w_rem_next;
    logic [N-1:0]  w_q_next;
    logic          w_unused_rem_msb;

    assign w_accept   = (r_state == IDLE) && !abort && in_valid;
    assign w_div_zero = (divisor == {N{1'b0}});
    assign w_last     = (r_count == CNT_ONE);
    assign w_shifted  = {r_rem[N-1:0], r_q[N-1]};
    assign w_rem_next = w_ge ? w_diff : w_shifted;
    assign w_q_next   = {r_q[N-2:0], w_ge};
    // The partial remainder MSB only absorbs the carry of a full-width divisor; it never feeds back.
    assign w_unused_rem_msb = r_rem[N];

    div_trial_sub #(.N(N)) u_trial (
        .shifted (w_shifted),
        .divisor (r_div),
        .diff    (w_diff),
        .ge      (w_ge)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = w_div_zero ? DONE : CALC;
                end else begin
                    w_state_next = IDLE;
                end
            end
            CALC: begin
                if (abort) begin
                    w_state_next = IDLE;
                end else if (w_last) begin
                    w_state_next = DONE;
                end else begin
                    w_state_next = CALC;
                end
            end
            DONE: begin
                if (abort || (r_out_valid && out_ready)) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = DONE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Next values of the registered handshake/status outputs
    always_comb begin
        w_out_valid_next = 1'b0;
        w_dbz_next       = 1'b0;
        case (r_state)
            IDLE: begin
                w_out_valid_next = 1'b0;
                w_dbz_next       = w_accept && w_div_zero;
            end
            CALC: begin
                w_out_valid_next = !abort && w_last;
                w_dbz_next       = 1'b0;
            end
            DONE: begin
                // A zero-divisor result enters DONE with out_valid low and raises it one edge later.
                w_out_valid_next = (w_state_next == DONE);
                w_dbz_next       = (w_state_next == DONE) ? r_dbz : 1'b0;
            end
            default: begin
                w_out_valid_next = 1'b0;
                w_dbz_next       = 1'b0;
            end
        endcase
    end

    // Output and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_dbz       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_out_valid <= w_out_valid_next;
            r_dbz       <= w_dbz_next;
            r_in_ready  <= (w_state_next == IDLE);
            r_busy      <= (w_state_next != IDLE);
        end
    end

    // Datapath: operand capture, per-cycle trial step and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= {CW{1'b0}};
            r_rem       <= {(N + 1){1'b0}};
            r_q         <= {N{1'b0}};
            r_div       <= {N{1'b0}};
            r_quotient  <= {N{1'b0}};
            r_remainder <= {N{1'b0}};
        end else if (w_accept) begin
            if (w_div_zero) begin
                r_quotient  <= {N{1'b1}};
                r_remainder <= dividend;
            end else begin
                r_div   <= divisor;
                r_q     <= dividend;
                r_rem   <= {(N + 1){1'b0}};
                r_count <= CNT_INIT;
            end
        end else if ((r_state == CALC) && !abort) begin
            r_rem   <= w_rem_next;
            r_q     <= w_q_next;
            r_count <= r_count - CNT_ONE;
            if (w_last) begin
                r_quotient  <= w_q_next;
                r_remainder <= w_rem_next[N-1:0];
            end else begin
                r_quotient  <= r_quotient;
                r_remainder <= r_remainder;
            end
        end else begin
            r_count <= r_count;
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;
    assign busy        = r_busy;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed plan cases plus random operands against
// an arithmetic reference (a / b, a % b, zero-divisor convention).
module tb_div_sequencer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        abort;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;
    logic        busy;

    int n_cmp;
    int n_bad;

    div_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .abort       (abort),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Runs one division; assumes it is entered 1 time unit after a rising edge.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int hold);
        logic [15:0] eq;
        logic [15:0] er;
        logic        ez;
        int          elat;
        int          cyc;
        if (b == 16'd0) begin
            eq = 16'hFFFF; er = a; ez = 1'b1; elat = 1;
        end else begin
            eq = a / b; er = a % b; ez = 1'b0; elat = 16;
        end
        check_eq("ready_before", {31'd0, in_ready}, 32'd1);
        dividend  = a;
        divisor   = b;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_eq($sformatf("latency %0d/%0d", a, b), cyc, elat);
        check_eq($sformatf("quot %0d/%0d", a, b), {16'd0, quotient}, {16'd0, eq});
        check_eq($sformatf("rem %0d/%0d", a, b), {16'd0, remainder}, {16'd0, er});
        check_eq($sformatf("dbz %0d/%0d", a, b), {31'd0, div_by_zero}, {31'd0, ez});
        check_eq("busy_done", {31'd0, busy}, 32'd1);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            dividend = 16'($urandom);
            divisor  = 16'($urandom);
            @(posedge clk); #1;
            check_eq("hold_valid", {31'd0, out_valid}, 32'd1);
            check_eq("hold_ready", {31'd0, in_ready}, 32'd0);
            check_eq("hold_quot", {16'd0, quotient}, {16'd0, eq});
            check_eq("hold_rem", {16'd0, remainder}, {16'd0, er});
            check_eq("hold_dbz", {31'd0, div_by_zero}, {31'd0, ez});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("post_valid", {31'd0, out_valid}, 32'd0);
        check_eq("post_ready", {31'd0, in_ready}, 32'd1);
        check_eq("post_dbz", {31'd0, div_by_zero}, 32'd0);
        check_eq("post_busy", {31'd0, busy}, 32'd0);
        check_eq("post_quot_held", {16'd0, quotient}, {16'd0, eq});
    endtask

    // Watches out_valid for a number of cycles; it must stay low.
    task automatic expect_quiet(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check_eq(tag, {31'd0, seen}, 32'd0);
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        dividend  = 16'd0;
        divisor   = 16'd0;
        abort     = 1'b0;
        out_ready = 1'b0;
        #12;
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_quot", {16'd0, quotient}, 32'd0);
        check_eq("rst_rem", {16'd0, remainder}, 32'd0);
        check_eq("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(16'd100, 16'd7, 0);
        run_op(16'hFFFF, 16'h8000, 0);
        run_op(16'hFFFF, 16'h0001, 0);
        run_op(16'd3, 16'd10, 0);
        run_op(16'd5, 16'd0, 0);
        run_op(16'd1000, 16'd3, 5);

        // Asynchronous reset in the middle of a calculation
        dividend = 16'd500; divisor = 16'd9; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("arst_busy", {31'd0, busy}, 32'd0);
        check_eq("arst_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("arst_quot", {16'd0, quotient}, 32'd0);
        check_eq("arst_rem", {16'd0, remainder}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        expect_quiet("arst_no_result", 20);
        run_op(16'd500, 16'd9, 0);

        // Abort mid-calculation
        dividend = 16'd100; divisor = 16'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        check_eq("abort_in_ready", {31'd0, in_ready}, 32'd1);
        expect_quiet("abort_no_result", 20);
        run_op(16'd42, 16'd6, 0);

        // Abort beats in_valid while idle
        abort = 1'b1; in_valid = 1'b1; dividend = 16'd9; divisor = 16'd0;
        @(posedge clk); #1;
        abort = 1'b0; in_valid = 1'b0;
        check_eq("idle_abort_busy", {31'd0, busy}, 32'd0);
        expect_quiet("idle_abort_no_result", 4);

        // Random operands, occasional zero divisors and back-pressure
        for (int k = 0; k < 30; k++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            ra = 16'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom >> $urandom_range(0, 15));
            run_op(ra, rb, int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
